// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the core data-memory path.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic              valid;
        logic [0:ADDR_W-1] addr;
        logic [0:DATA_W-1] data;
    } sb_entry_t;

    // What the single SRAM port is doing in a given cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DRAIN = 2'd3
    } port_op_e;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Core-side and SRAM-side bundles for the data-memory store buffer.
interface dmem_core_if #(
    parameter int unsigned ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_mem_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4
);
    logic                      core_mem_en;
    logic                      core_mem_wr_en;
    logic [0:ADDR_W-1]         core_addr;
    logic [0:DATA_W-1]         core_wdata;
    logic [0:DATA_W-1]         core_rdata;
    logic                      core_stall;
    logic                      sb_empty;
    logic [0:$clog2(DEPTH)]    sb_count;

    modport master (
        output core_mem_en, core_mem_wr_en, core_addr, core_wdata,
        input  core_rdata, core_stall, sb_empty, sb_count
    );
    modport slave (
        input  core_mem_en, core_mem_wr_en, core_addr, core_wdata,
        output core_rdata, core_stall, sb_empty, sb_count
    );
endinterface

interface dmem_sram_if #(
    parameter int unsigned ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_mem_pkg::DATA_W
);
    logic              sram_en;
    logic              sram_wr_en;
    logic [0:ADDR_W-1] sram_addr;
    logic [0:DATA_W-1] sram_wdata;
    logic [0:DATA_W-1] sram_rdata;

    modport master (
        output sram_en, sram_wr_en, sram_addr, sram_wdata,
        input  sram_rdata
    );
    modport slave (
        input  sram_en, sram_wr_en, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/dmem_store_buffer_cam.sv
// Store-entry array: write at tail, clear at head, youngest-match address search.
module sb_cam_array #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_mem_pkg::DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_idx_i,
    input  logic [0:ADDR_W-1] wr_addr_i,
    input  logic [0:DATA_W-1] wr_data_i,
    input  logic              clr_en_i,
    input  logic [PTR_W-1:0]  clr_idx_i,
    input  logic [PTR_W-1:0]  head_i,
    input  logic [0:ADDR_W-1] srch_addr_i,
    output logic              hit_o,
    output logic [0:DATA_W-1] hit_data_o,
    output logic [0:ADDR_W-1] head_addr_o,
    output logic [0:DATA_W-1] head_data_o
);

    logic              valid_q [DEPTH];
    logic [0:ADDR_W-1] addr_q  [DEPTH];
    logic [0:DATA_W-1] data_q  [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (clr_en_i) begin
                valid_q[clr_idx_i] <= 1'b0;
            end
            if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                addr_q[wr_idx_i]  <= wr_addr_i;
                data_q[wr_idx_i]  <= wr_data_i;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    logic [PTR_W-1:0] idx;
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == srch_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[head_i];
    assign head_data_o = data_q[head_i];

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the core data port and a single-port SRAM, with load forwarding.
module dmem_store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_mem_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    dmem_core_if.slave   core,
    dmem_sram_if.master  sram
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              load_pending_q, fwd_hit_q;
    logic [0:DATA_W-1] fwd_data_q;

    logic              is_load, is_store, full, store_acc, drain;
    logic              cam_hit;
    logic [0:DATA_W-1] cam_data, head_data;
    logic [0:ADDR_W-1] head_addr;
    port_op_e          op;

    assign is_load   = core.core_mem_en & ~core.core_mem_wr_en;
    assign is_store  = core.core_mem_en &  core.core_mem_wr_en;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign store_acc = is_store & ~full;
    assign drain     = ~is_load & (count_q != '0);

    sb_cam_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cam (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (store_acc),
        .wr_idx_i    (tail_q),
        .wr_addr_i   (core.core_addr),
        .wr_data_i   (core.core_wdata),
        .clr_en_i    (drain),
        .clr_idx_i   (head_q),
        .head_i      (head_q),
        .srch_addr_i (core.core_addr),
        .hit_o       (cam_hit),
        .hit_data_o  (cam_data),
        .head_addr_o (head_addr),
        .head_data_o (head_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            load_pending_q <= 1'b0;
            fwd_hit_q      <= 1'b0;
            fwd_data_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            load_pending_q <= is_load;
            fwd_hit_q      <= is_load & cam_hit;
            fwd_data_q     <= is_load ? cam_data : '0;
        end
    end

    always_comb begin
        head_d  = drain     ? head_q + PTR_W'(1) : head_q;
        tail_d  = store_acc ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(store_acc) - CNT_W'(drain);
    end

    // Reset gates the port so a load presented during reset cannot reach the SRAM.
    always_comb begin
        op = IDLE;
        if (!reset) begin
            if (is_load)    op = LOAD;
            else if (drain) op = DRAIN;
        end
    end

    always_comb begin
        sram.sram_en    = 1'b0;
        sram.sram_wr_en = 1'b0;
        sram.sram_addr  = '0;
        sram.sram_wdata = '0;
        case (op)
            LOAD: begin
                sram.sram_en   = 1'b1;
                sram.sram_addr = core.core_addr;
            end
            DRAIN: begin
                sram.sram_en    = 1'b1;
                sram.sram_wr_en = 1'b1;
                sram.sram_addr  = head_addr;
                sram.sram_wdata = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        core.core_stall = is_store & full & ~reset;
        core.core_rdata = !load_pending_q ? '0
                        : (fwd_hit_q ? fwd_data_q : sram.sram_rdata);
        core.sb_empty   = (count_q == '0);
        core.sb_count   = count_q;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer against a queue-based store-buffer model.
module tb_dmem_store_buffer;
    import cpu_mem_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_core_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) core ();
    dmem_sram_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core),
        .sram  (sram)
    );

    // Environment SRAM: one-cycle read latency.
    logic [63:0] mem [logic [31:0]];

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (sram.sram_en) begin
            if (sram.sram_wr_en) mem[sram.sram_addr] = sram.sram_wdata;
            else                 sram.sram_rdata <= mem_rd(sram.sram_addr);
        end
    end

    // Reference model: FIFO of posted stores plus the memory image they drain into.
    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] ref_mem [logic [31:0]];
    bit          pend;
    logic [63:0] pend_data;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit wr, input logic [31:0] a, input logic [63:0] d);
        bit          ld, st, full, drn, hit;
        logic [63:0] fwd;
        @(negedge clk);
        core.core_mem_en    = en;
        core.core_mem_wr_en = wr;
        core.core_addr      = a;
        core.core_wdata     = d;
        #1;
        ld   = en && !wr;
        st   = en && wr;
        full = (q.size() == DEPTH);
        drn  = !ld && (q.size() > 0);
        check_eq("rdata", core.core_rdata, pend ? pend_data : 64'd0);
        check_eq("count", 64'(core.sb_count), 64'(q.size()));
        check_eq("empty", 64'(core.sb_empty), 64'(q.size() == 0));
        check_eq("stall", 64'(core.core_stall), 64'(st && full));
        check_eq("sram_en", 64'(sram.sram_en), 64'(ld || drn));
        check_eq("sram_wr", 64'(sram.sram_wr_en), 64'(drn));
        check_eq("sram_addr", 64'(sram.sram_addr), ld ? 64'(a) : (drn ? 64'(q[0].a) : 64'd0));
        check_eq("sram_wdata", sram.sram_wdata, drn ? q[0].d : 64'd0);
        if (ld) begin
            hit = 1'b0;
            fwd = 64'd0;
            foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; fwd = q[i].d; end
            pend      = 1'b1;
            pend_data = hit ? fwd : ref_rd(a);
        end else begin
            pend = 1'b0;
        end
        if (drn) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (st && !full) q.push_back('{a: a, d: d});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset               = 1'b1;
        core.core_mem_en    = 1'b1;
        core.core_mem_wr_en = 1'b0;
        core.core_addr      = 32'h10;
        #1;
        check_eq("rst_count", 64'(core.sb_count), 64'd0);
        check_eq("rst_empty", 64'(core.sb_empty), 64'd1);
        check_eq("rst_rdata", core.core_rdata, 64'd0);
        check_eq("rst_sram_en", 64'(sram.sram_en), 64'd0);
        check_eq("rst_stall", 64'(core.core_stall), 64'd0);
        q.delete();
        pend = 1'b0;
        @(negedge clk);
        core.core_mem_en = 1'b0;
        reset            = 1'b0;
    endtask

    logic [31:0] addr_pool [5];

    initial begin
        addr_pool = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        reset               = 1'b1;
        core.core_mem_en    = 1'b0;
        core.core_mem_wr_en = 1'b0;
        core.core_addr      = '0;
        core.core_wdata     = '0;
        pend                = 1'b0;
        mem[32'h10]     = 64'hAAAA_0000_0000_0001;
        ref_mem[32'h10] = 64'hAAAA_0000_0000_0001;
        apply_reset();

        // Plain load from SRAM, then store-to-load forwarding and its later drain.
        step(1, 0, 32'h10, 0);
        step(0, 0, 0, 0);
        step(1, 1, 32'h20, 64'h1111);
        step(1, 0, 32'h20, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Same-address stores: forwarding returns the youngest.
        step(1, 1, 32'h30, 64'd1);
        step(1, 1, 32'h30, 64'd2);
        step(1, 0, 32'h30, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("mem30", mem_rd(32'h30), 64'd2);

        // Stores interleaved with loads, then a burst of stores.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h40 + 32'(i), 64'h100 + 64'(i));
            step(1, 0, 32'h99, 0);
        end
        for (int i = 0; i < 5; i++) step(1, 1, 32'h60 + 32'(i), 64'h200 + 64'(i));

        // Reset while entries are buffered, then idle with no further writes.
        step(1, 1, 32'h70, 64'h7);
        step(1, 0, 32'h70, 0);
        apply_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            logic [31:0] ra;
            r  = $urandom_range(0, 9);
            ra = ($urandom_range(0, 4) != 0) ? addr_pool[$urandom_range(0, 4)] : $urandom;
            if (r < 5)      step(1, 0, ra, 0);
            else if (r < 8) step(1, 1, ra, {$urandom, $urandom});
            else            step(0, 0, 0, 0);
        end

        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0);
        check_eq("mem_size", 64'(mem.num()), 64'(ref_mem.num()));
        foreach (ref_mem[k]) check_eq("mem_img", mem_rd(k), ref_mem[k]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
